// File: rtl/accel_csr_ctrl.sv
// Wishbone CSR block that launches a compute core and tracks its completion.
// Optional BUSY watchdog enabled by defining ACCEL_CSR_WATCHDOG_EN.
module accel_csr_ctrl #(
    parameter int DATA_W         = 32,
    parameter int NUM_REGS       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [31:0]                wb_adr_i,
    input  logic [DATA_W-1:0]          wb_dat_i,
    input  logic [DATA_W/8-1:0]        wb_sel_i,
    output logic [DATA_W-1:0]          wb_dat_o,
    output logic                       wb_ack_o,
    output logic [NUM_REGS*DATA_W-1:0] cfg_o,
    output logic                       core_start_o,
    input  logic                       core_done_i,
    output logic                       irq_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              req_s;
    logic              wr_s;
    logic              ctrl_wr_s;
    logic              start_s;
    logic [3:0]        idx_s;
    logic              ack_r;
    logic [DATA_W-1:0] dat_r;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] ctrl_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              done_set_s;
    logic              err_set_s;
    logic              err_s;
    logic              err_nxt_s;
    logic              irq_en_r;
    logic              irq_en_nxt_s;
    logic              wdog_exp_s;
    logic              core_start_r;
    logic              irq_r;
    logic [DATA_W-1:0] regs_r [1:NUM_REGS-1];

    assign idx_s     = wb_adr_i[5:2];
    assign req_s     = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr_s      = req_s & wb_we_i;
    assign ctrl_wr_s = wr_s & (idx_s == 4'd0) & wb_sel_i[0];
    assign start_s   = ctrl_wr_s & wb_dat_i[0] & (state_r == ST_IDLE);

    assign wb_ack_o     = ack_r;
    assign wb_dat_o     = dat_r;
    assign core_start_o = core_start_r;
    assign irq_o        = irq_r;

`ifdef ACCEL_CSR_WATCHDOG_EN
    logic [15:0] wdog_r;
    logic        err_r;
    logic        unused_s;

    assign wdog_exp_s = (wdog_r == 16'(TIMEOUT_CYCLES - 1));
    assign err_s      = err_r;
    assign err_nxt_s  = err_set_s | (err_r & ~(ctrl_wr_s & wb_dat_i[4]));
    assign unused_s   = ^{wb_adr_i[31:6], wb_adr_i[1:0]};

    // Watchdog counter: cleared while launching, counts every BUSY cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_r <= 16'd0;
        end else if (state_r == ST_LAUNCH) begin
            wdog_r <= 16'd0;
        end else if (state_r == ST_BUSY) begin
            wdog_r <= wdog_r + 16'd1;
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // Sticky ERR flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt_s;
        end
    end
`else
    logic unused_s;

    assign wdog_exp_s = 1'b0;
    assign err_s      = 1'b0;
    assign err_nxt_s  = 1'b0;
    assign unused_s   = ^{wb_adr_i[31:6], wb_adr_i[1:0], err_set_s};
`endif

    // FSM next state and the DONE/ERR set events it produces.
    always_comb begin
        state_nxt_s = state_r;
        done_set_s  = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_BUSY;
            end
            ST_BUSY: begin
                // Completion on the expiry cycle takes precedence over the timeout.
                if (core_done_i) begin
                    state_nxt_s = ST_IDLE;
                    done_set_s  = 1'b1;
                end else if (wdog_exp_s) begin
                    state_nxt_s = ST_IDLE;
                    done_set_s  = 1'b1;
                    err_set_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // CTRL next values; a hardware set beats a same-cycle write-1-to-clear.
    always_comb begin
        done_nxt_s = done_set_s | (done_r & ~(ctrl_wr_s & wb_dat_i[2]));
        if (ctrl_wr_s) begin
            irq_en_nxt_s = wb_dat_i[3];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // CTRL read view.
    always_comb begin
        ctrl_s    = '0;
        ctrl_s[1] = (state_r != ST_IDLE);
        ctrl_s[2] = done_r;
        ctrl_s[3] = irq_en_r;
        ctrl_s[4] = err_s;
    end

    // AND-OR read mux; indices without a register fall through to zero.
    always_comb begin
        rd_data_s = ctrl_s & {DATA_W{idx_s == 4'd0}};
        for (int k = 1; k < NUM_REGS; k++) begin
            rd_data_s = rd_data_s | (regs_r[k] & {DATA_W{idx_s == 4'(k)}});
        end
    end

    // FSM, CTRL flags, start pulse and interrupt flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            done_r       <= 1'b0;
            irq_en_r     <= 1'b0;
            core_start_r <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            done_r       <= done_nxt_s;
            irq_en_r     <= irq_en_nxt_s;
            core_start_r <= (state_nxt_s == ST_LAUNCH);
            irq_r        <= (done_nxt_s | err_nxt_s) & irq_en_nxt_s;
        end
    end

    // Wishbone acknowledge and read data, one cycle after the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_r <= 1'b0;
            dat_r <= '0;
        end else begin
            ack_r <= req_s;
            dat_r <= (req_s & ~wb_we_i) ? rd_data_s : '0;
        end
    end

    // General-purpose registers with per-byte write enables.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_r[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (wr_s && (idx_s == 4'(k))) begin
                    for (int b = 0; b < SEL_W; b++) begin
                        if (wb_sel_i[b]) begin
                            regs_r[k][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    assign cfg_o[0 +: DATA_W] = ctrl_s;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_cfg
            assign cfg_o[g*DATA_W +: DATA_W] = regs_r[g];
        end
    endgenerate

endmodule
